// File: rtl/sel_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sel_sequencer_pkg
// Description : Shared types and constants for the select-code sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sel_sequencer_pkg;

    localparam int CODE_W = 2;

    localparam logic [CODE_W-1:0] MODE_BIN_UP = 2'b00;
    localparam logic [CODE_W-1:0] MODE_GRAY   = 2'b01;
    localparam logic [CODE_W-1:0] MODE_BIN_DN = 2'b10;
    localparam logic [CODE_W-1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage : sel_sequencer_pkg
`default_nettype wire

// File: rtl/sel_code_map.sv
`default_nettype none
// ============================================================================
// Module      : sel_code_map
// Description : Maps a sweep step to the select code for the chosen order.
// Revision    : 1.0 - initial release
// ============================================================================
module sel_code_map
    import sel_sequencer_pkg::*;
(
    input  logic [CODE_W-1:0] mode,
    input  logic [CODE_W-1:0] step,
    output logic [CODE_W-1:0] x
);

    // The reserved mode falls into the default and sweeps binary up.
    always_comb begin
        case (mode)
            MODE_GRAY:   x = step ^ {1'b0, step[CODE_W-1]};
            MODE_BIN_DN: x = ~step;
            default:     x = step;
        endcase
    end

endmodule : sel_code_map
`default_nettype wire

// File: rtl/sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sel_sequencer
// Description : Sweeps the four select codes over a valid/ready handshake,
//               dwelling after each acceptance, for a fixed number of passes.
// Revision    : 1.0 - initial release
// ============================================================================
module sel_sequencer
    import sel_sequencer_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int PASSES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [1:0]                       mode,
    output logic [1:0]                       x,
    output logic                             x_valid,
    input  logic                             x_ready,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(PASSES+1)-1:0]      pass_cnt
);

    localparam int c_dwell_w = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int c_pass_w  = $clog2(PASSES + 1);

    localparam logic [c_dwell_w-1:0] c_dwell_load = c_dwell_w'(DWELL - 1);
    localparam logic [c_pass_w-1:0]  c_passes     = c_pass_w'(PASSES);
    localparam logic [CODE_W-1:0]    c_last_step  = 2'd3;

    state_t                r_state;
    state_t                w_next_state;
    logic [CODE_W-1:0]     r_mode;
    logic [CODE_W-1:0]     r_step;
    logic [CODE_W-1:0]     r_x;
    logic [c_dwell_w-1:0]  r_dwell;
    logic [c_pass_w-1:0]   r_pass_cnt;

    logic [CODE_W-1:0]     w_code;
    logic [c_pass_w-1:0]   w_pass_inc;
    logic                  w_start_run;
    logic                  w_accept;
    logic                  w_step_adv;
    logic                  w_pass_end;

    sel_code_map u_code_map (
        .mode (r_mode),
        .step (r_step),
        .x    (w_code)
    );

    assign w_pass_inc = r_pass_cnt + 1'b1;
    assign pass_cnt   = r_pass_cnt;

    always_comb begin
        w_next_state = r_state;
        w_start_run  = 1'b0;
        w_accept     = 1'b0;
        w_step_adv   = 1'b0;
        w_pass_end   = 1'b0;
        x_valid      = 1'b0;
        done         = 1'b0;
        busy         = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_run  = 1'b1;
                    w_next_state = PRESENT;
                end
            end
            PRESENT: begin
                x_valid = 1'b1;
                if (x_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (r_dwell == '0) begin
                    if (r_step == c_last_step) begin
                        w_pass_end   = 1'b1;
                        w_next_state = (w_pass_inc == c_passes) ? DONE : PRESENT;
                    end else begin
                        w_step_adv   = 1'b1;
                        w_next_state = PRESENT;
                    end
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Outside PRESENT the last offered code stays on the bus.
        x = x_valid ? w_code : r_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mode     <= MODE_BIN_UP;
            r_step     <= '0;
            r_x        <= '0;
            r_dwell    <= '0;
            r_pass_cnt <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state == PRESENT) begin
                r_x <= w_code;
            end

            if (w_accept) begin
                r_dwell <= c_dwell_load;
            end else if ((r_state == HOLD) && (r_dwell != '0)) begin
                r_dwell <= r_dwell - 1'b1;
            end

            if (w_start_run) begin
                r_mode     <= mode;
                r_step     <= '0;
                r_pass_cnt <= '0;
            end else if (w_pass_end) begin
                r_step     <= '0;
                r_pass_cnt <= w_pass_inc;
            end else if (w_step_adv) begin
                r_step     <= r_step + 1'b1;
            end
        end
    end

endmodule : sel_sequencer
`default_nettype wire

// File: tb/tb_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sel_sequencer
// Description : Self-checking bench for sel_sequencer against a code-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic       x_ready;
    logic [1:0] mode;

    logic [1:0] xa, xb;
    logic       va, vb, busy_a, busy_b, done_a, done_b;
    logic [1:0] pc_a;
    logic [0:0] pc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sel_sequencer #(.DWELL(4), .PASSES(2)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .mode     (mode),
        .x        (xa),
        .x_valid  (va),
        .x_ready  (x_ready),
        .busy     (busy_a),
        .done     (done_a),
        .pass_cnt (pc_a)
    );

    sel_sequencer #(.DWELL(1), .PASSES(1)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .mode     (mode),
        .x        (xb),
        .x_valid  (vb),
        .x_ready  (x_ready),
        .busy     (busy_b),
        .done     (done_b),
        .pass_cnt (pc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] code_of(input logic [1:0] m, input int s);
        logic [1:0] seq [4];
        case (m)
            2'b01:   seq = '{2'd0, 2'd1, 2'd3, 2'd2};
            2'b10:   seq = '{2'd3, 2'd2, 2'd1, 2'd0};
            default: seq = '{2'd0, 2'd1, 2'd2, 2'd3};
        endcase
        return seq[s];
    endfunction

    task automatic sample(input int sel, output logic [1:0] ox, output logic ov,
                          output logic ob, output logic od, output int opc);
        if (sel == 0) begin
            ox = xa; ov = va; ob = busy_a; od = done_a; opc = int'(pc_a);
        end else begin
            ox = xb; ov = vb; ob = busy_b; od = done_b; opc = int'(pc_b);
        end
    endtask

    // Model: a run is the list of codes; each is offered until accepted,
    // followed by d idle cycles; after the last one comes a single done cycle.
    task automatic run(input int sel, input int d, input int p, input logic [1:0] m,
                       input int bp_pct, input int stall_idx, input int stall_len,
                       input bit noise, input int exp_done);
        logic [1:0] codes [$];
        int         n, idx, phase, left, stalled, c, done_c, opc;
        logic [1:0] ox;
        logic       ov, ob, od, rdy;

        codes.delete();
        for (int ps = 0; ps < p; ps++)
            for (int s = 0; s < 4; s++)
                codes.push_back(code_of(m, s));
        n = codes.size();

        mode    = m;
        x_ready = 1'b0;
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;

        idx = 0; phase = 0; left = 0; stalled = 0; c = 1; done_c = -1;
        while (phase != 3 && c < 2000) begin
            sample(sel, ox, ov, ob, od, opc);
            chk("busy", ob, 1);
            chk("x_valid", ov, phase == 0);
            chk("done", od, phase == 2);
            chk("pass_cnt", opc, idx / 4);
            if (phase == 0) chk("x", ox, codes[idx]);
            else if (phase == 1) chk("x_hold", ox, codes[idx]);
            else chk("x_hold_end", ox, codes[n-1]);
            if (phase == 2) done_c = c;

            rdy = ($urandom_range(99) >= bp_pct);
            if (phase == 0 && idx == stall_idx && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            x_ready = rdy;
            if (noise) begin
                mode = 2'($urandom_range(3));
                if (sel == 0) start_a = (phase == 2) ? 1'b1 : 1'($urandom_range(1));
                else          start_b = (phase == 2) ? 1'b1 : 1'($urandom_range(1));
            end

            case (phase)
                0: if (rdy) begin left = d; phase = 1; end
                1: begin
                    left--;
                    if (left == 0) begin
                        idx++;
                        phase = (idx == n) ? 2 : 0;
                    end
                end
                default: phase = 3;
            endcase
            tick();
            c++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk("run_timeout", phase, 3);

        sample(sel, ox, ov, ob, od, opc);
        chk("idle_busy", ob, 0);
        chk("idle_x_valid", ov, 0);
        chk("idle_done", od, 0);
        chk("idle_pass_cnt", opc, p);
        chk("idle_x", ox, codes[n-1]);
        if (exp_done >= 0) chk("done_cycle", done_c, exp_done);
    endtask

    initial begin
        logic [1:0] ox;
        logic       ov, ob, od;
        int         opc;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 2'b00; x_ready = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sample(s, ox, ov, ob, od, opc);
            chk("rst_x", ox, 0);
            chk("rst_x_valid", ov, 0);
            chk("rst_busy", ob, 0);
            chk("rst_done", od, 0);
            chk("rst_pass_cnt", opc, 0);
        end
        rst = 1'b0;
        tick();

        run(0, 4, 2, 2'b00, 0, -1, 0, 1'b0, 41);

        // Abort a run at cycle 10
        mode = 2'b00; x_ready = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample(0, ox, ov, ob, od, opc);
        chk("abort_busy", ob, 0);
        chk("abort_x_valid", ov, 0);
        chk("abort_done", od, 0);
        chk("abort_pass_cnt", opc, 0);
        chk("abort_x", ox, 0);
        tick();
        sample(0, ox, ov, ob, od, opc);
        chk("abort_no_done", od, 0);
        chk("abort_still_idle", ob, 0);
        run(0, 4, 2, 2'b00, 0, -1, 0, 1'b0, 41);

        run(0, 4, 2, 2'b01, 0, -1, 0, 1'b0, 41);
        run(0, 4, 2, 2'b10, 0, -1, 0, 1'b0, 41);
        run(0, 4, 2, 2'b11, 0, -1, 0, 1'b0, 41);

        run(0, 4, 2, 2'b00, 0, 1, 7, 1'b0, 48);

        // Busy-time noise, start in the done cycle, then restart right away
        run(0, 4, 2, 2'b10, 0, -1, 0, 1'b1, 41);
        run(0, 4, 2, 2'b01, 0, -1, 0, 1'b0, 41);

        repeat (4) run(0, 4, 2, 2'($urandom_range(3)), 30, -1, 0, 1'b1, -1);

        run(1, 1, 1, 2'b00, 0, -1, 0, 1'b0, 9);
        run(1, 1, 1, 2'b01, 0, -1, 0, 1'b0, 9);
        repeat (3) run(1, 1, 1, 2'($urandom_range(3)), 25, -1, 0, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sel_sequencer
`default_nettype wire
